spi_cmd_arbiter: RTL and testbench

Shares the single SParkDream SPI controller between `N_REQ` command requesters, e.g. the AXI register path and an autonomous readback poller. Requests are accepted by round-robin arbitration and sequenced one at a time onto the controller's command inputs. Each completed transfer is returned to the requester that issued it as a one-cycle response. The block sits between the AXI memory map and `spi_interface`, in the `S_AXI_ACLK` domain.

---
 rtl/spi_arb_pkg.sv | 28 ++
 rtl/spi_cmd_arbiter_rr.sv | 33 +++
 rtl/spi_cmd_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI command arbiter: FSM state encoding, default field
// widths and the latched command record.
package spi_arb_pkg;

  localparam int SPI_ADDR_W = 10;
  localparam int SPI_LEN_W  = 8;
  localparam int SPI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } spi_arb_state_t;

  typedef struct packed {
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_LEN_W-1:0]  len;
    logic [SPI_DATA_W-1:0] wdata;
  } spi_cmd_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after the priority pointer, wrapping modulo N_REQ.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  always_comb begin : p_arb
    logic v_found;
    int   v_idx;
    o_grant     = '0;
    o_grant_idx = '0;
    v_found     = 1'b0;
    v_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = int'(i_ptr) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!v_found && i_req[v_idx]) begin
        v_found            = 1'b1;
        o_grant[v_idx]     = 1'b1;
        o_grant_idx        = IDX_W'(v_idx);
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin sharing of one SPI controller between N_REQ command requesters.
// Define SPI_ARB_TIMEOUT_EN to add the WAIT watchdog (spi_abort / rsp_err).
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = SPI_ADDR_W,
  parameter int LEN_W       = SPI_LEN_W,
  parameter int DATA_W      = SPI_DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic                    spi_read_write,
  output logic [ADDR_W-1:0]       spi_address,
  output logic [LEN_W-1:0]        spi_data_len,
  output logic [DATA_W-1:0]       spi_write_data,
  input  logic                    spi_done,
  input  logic [DATA_W-1:0]       spi_read_data,
  output logic                    spi_abort
);

  localparam int IDX_W = idx_w(N_REQ);

  spi_arb_state_t   r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, r_grant, w_grant_idx;
  logic [N_REQ-1:0] w_grant;
  spi_cmd_t         r_cmd, w_cmd_sel;
  logic [DATA_W-1:0] r_rdata;
  logic             w_accept, w_timeout;

  logic [ADDR_W-1:0] w_addr  [N_REQ];
  logic [LEN_W-1:0]  w_len   [N_REQ];
  logic [DATA_W-1:0] w_wdata [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_addr[gi]    = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_len[gi]     = req_len[gi*LEN_W +: LEN_W];
      assign w_wdata[gi]   = req_wdata[gi*DATA_W +: DATA_W];
      assign rsp_valid[gi] = (r_state == RESP) && (r_grant == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req_ready = (r_state == IDLE && S_AXI_ARESETN) ? w_grant : '0;
  assign w_accept  = (r_state == IDLE) && (|w_grant);

  always_comb begin
    w_cmd_sel       = '0;
    w_cmd_sel.rw    = req_rw[w_grant_idx];
    w_cmd_sel.addr  = SPI_ADDR_W'(w_addr[w_grant_idx]);
    w_cmd_sel.len   = SPI_LEN_W'(w_len[w_grant_idx]);
    w_cmd_sel.wdata = SPI_DATA_W'(w_wdata[w_grant_idx]);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (spi_done || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cmd   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cmd   <= w_cmd_sel;
        r_grant <= w_grant_idx;
        r_ptr   <= (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      if (r_state == WAIT) begin
        if (spi_done)       r_rdata <= r_cmd.rw ? '0 : spi_read_data;
        else if (w_timeout) r_rdata <= '0;
      end
    end
  end

  assign spi_start      = (r_state == ISSUE);
  assign spi_read_write = r_cmd.rw;
  assign spi_address    = ADDR_W'(r_cmd.addr);
  assign spi_data_len   = LEN_W'(r_cmd.len);
  assign spi_write_data = DATA_W'(r_cmd.wdata);
  assign rsp_rdata      = (r_state == RESP) ? r_rdata : '0;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // A done arriving on the timeout cycle takes precedence over the abort.
  assign w_timeout = (r_state == WAIT) && !spi_done && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ISSUE)     r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == WAIT) begin
        if (spi_done)       r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign spi_abort = w_timeout;
  assign rsp_err   = (r_state == RESP) && r_err;
`else
  assign w_timeout = 1'b0;
  assign spi_abort = 1'b0;
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter: directed vector table, corner
// sequences and a randomized run against a cycle-timeline reference model.
module tb_spi_cmd_arbiter;
  localparam int N  = 2;
  localparam int AW = 10;
  localparam int LW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, req_rw = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, spi_start, spi_read_write, spi_abort;
  logic [AW-1:0]   spi_address;
  logic [LW-1:0]   spi_data_len;
  logic [DW-1:0]   spi_write_data;
  logic            spi_done = 1'b0;
  logic [DW-1:0]   spi_read_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .spi_start(spi_start), .spi_read_write(spi_read_write), .spi_address(spi_address),
    .spi_data_len(spi_data_len), .spi_write_data(spi_write_data),
    .spi_done(spi_done), .spi_read_data(spi_read_data), .spi_abort(spi_abort)
  );

  typedef struct {
    int          idx;
    logic        rw;
    logic [9:0]  addr;
    logic [7:0]  len;
    logic [31:0] wdata;
    logic [31:0] spi_rdata;
    int          delay;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [9:0] a,
                         input logic [7:0] l, input logic [31:0] wd);
    req_valid[i]          = 1'b1;
    req_rw[i]             = rw;
    req_addr[i*AW +: AW]  = a;
    req_len[i*LW +: LW]   = l;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_err, spi_start, spi_read_write,
                            spi_abort, spi_address, spi_data_len}), 64'd0);
    chk({tag, "_data"}, {rsp_rdata, spi_write_data}, 64'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    spi_done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transfer: accept, launch, done after v.delay cycles, response.
  task automatic run_vec(input vec_t v, input int n);
    @(negedge clk);
    set_req(v.idx, v.rw, v.addr, v.len, v.wdata);
    #1 chk($sformatf("v%0d_ready", n), 64'(req_ready), 64'(1 << v.idx));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk($sformatf("v%0d_start", n), 64'(spi_start), 64'd1);
    chk($sformatf("v%0d_cmd", n), {spi_read_write, spi_address, spi_data_len, spi_write_data},
        {v.rw, v.addr, v.len, v.wdata});
    for (int d = 1; d < v.delay; d++) begin
      @(negedge clk);
      #1 chk($sformatf("v%0d_wait", n), 64'({spi_start, rsp_valid}), 64'd0);
    end
    @(negedge clk);
    spi_done = 1'b1;
    spi_read_data = v.spi_rdata;
    @(negedge clk);
    spi_done = 1'b0;
    spi_read_data = $urandom;
    #1;
    chk($sformatf("v%0d_rsp", n), 64'({rsp_valid, rsp_err}), 64'({2'(1 << v.idx), 1'b0}));
    chk($sformatf("v%0d_rdata", n), 64'(rsp_rdata), 64'(v.exp_rdata));
    @(negedge clk);
    #1 chk($sformatf("v%0d_after", n), 64'({rsp_valid, spi_address}), 64'({2'b00, v.addr}));
  endtask

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    vec_t vecs[5];
    logic [9:0] c_addr[N];
    int bad;

    vecs[0] = '{0, 1'b0, 10'h155, 8'd8,   32'h0,        32'h000000A5, 5, 32'h000000A5};
    vecs[1] = '{1, 1'b1, 10'h3FF, 8'd32,  32'hDEADBEEF, 32'h12345678, 3, 32'h0};
    vecs[2] = '{0, 1'b1, 10'h000, 8'd16,  32'h0000FFFF, 32'hFFFFFFFF, 1, 32'h0};
    vecs[3] = '{1, 1'b0, 10'h2AA, 8'hFF,  32'h0,        32'h80000001, 2, 32'h80000001};
    vecs[4] = '{0, 1'b0, 10'h001, 8'd1,   32'h0,        32'h00000000, 7, 32'h0};

    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // spi_done while idle must not produce a response.
    @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    #1 chk("late_done0", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1 chk("late_done1", 64'(rsp_valid), 64'd0);

    // Contention from reset: grants alternate 0,1,0,1 with the matching address.
    do_reset();
    c_addr[0] = 10'h100;
    c_addr[1] = 10'h101;
    set_req(0, 1'b0, c_addr[0], 8'd4, 32'h0);
    set_req(1, 1'b1, c_addr[1], 8'd4, 32'h11110000);
    for (int t = 0; t < 4; t++) begin
      int g;
      g = t % 2;
      #1 chk($sformatf("cont%0d_grant", t), 64'(req_ready), 64'(1 << g));
      @(negedge clk);
      #1;
      chk($sformatf("cont%0d_start", t), 64'({spi_start, spi_address}), 64'({1'b1, c_addr[g]}));
      c_addr[g] = c_addr[g] + 10'h010;
      req_addr[g*AW +: AW] = c_addr[g];
      chk($sformatf("cont%0d_pend", t), 64'(req_ready), 64'd0);
      @(negedge clk);
      spi_done = 1'b1;
      spi_read_data = 32'hC0DE0000 + t;
      @(negedge clk);
      spi_done = 1'b0;
      #1;
      chk($sformatf("cont%0d_rsp", t), 64'(rsp_valid), 64'(1 << g));
      chk($sformatf("cont%0d_rdata", t), 64'(rsp_rdata), (g == 0) ? 64'(32'hC0DE0000 + t) : 64'd0);
      if (t == 3) req_valid = '0;
      @(negedge clk);
    end

    // Stalled controller: watchdog abort when enabled, indefinite WAIT otherwise.
    set_req(0, 1'b0, 10'h155, 8'd8, 32'h0);
    @(negedge clk);
    req_valid = '0;
    #1 chk("stall_start", 64'(spi_start), 64'd1);
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      #1 chk("to_wait", 64'({spi_abort, rsp_valid}), 64'd0);
    end
    @(negedge clk);
    #1 chk("to_abort", 64'({spi_abort, rsp_valid}), 64'({1'b1, 2'b00}));
    @(negedge clk);
    #1 chk("to_rsp", 64'({spi_abort, rsp_valid, rsp_err, rsp_rdata}),
           64'({1'b0, 2'b01, 1'b1, 32'h0}));
    @(negedge clk);
    set_req(0, 1'b0, 10'h155, 8'd8, 32'h0);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
`else
    set_req(1, 1'b1, 10'h0AA, 8'd4, 32'h5A5A5A5A);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1 if (rsp_valid != 0 || req_ready != 0 || spi_abort || rsp_err) bad++;
    end
    chk("stall_1000", 64'(bad), 64'd0);
`endif

    // Reset while in WAIT: outputs drop at once, req1 served first afterwards.
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 10'h0AA, 8'd4, 32'h5A5A5A5A);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_wait");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready", 64'({req_ready, rsp_valid}), 64'({2'b10, 2'b00}));
    @(negedge clk);
    req_valid = '0;
    #1 chk("rst_rel_start", 64'({spi_start, rsp_valid, spi_address}), 64'({1'b1, 2'b00, 10'h0AA}));
    @(negedge clk);
    spi_done = 1'b1;
    spi_read_data = 32'h77777777;
    @(negedge clk);
    spi_done = 1'b0;
    #1 chk("rst_rel_rsp", 64'({rsp_valid, rsp_rdata}), 64'({2'b10, 32'h0}));

    // Randomized traffic checked against an event-timeline model.
    do_reset();
    begin
      int m_ptr, t_start, t_done, t_rsp, t_free, m_g, m_drop;
      logic [31:0] m_rd, m_exp;
      logic [9:0]  m_addr;
      logic        m_rw;
      logic [N-1:0] exp_ready;
      m_ptr = 0; t_start = -1; t_done = -1; t_rsp = -1; t_free = 0; m_g = 0; m_drop = -1;
      m_rd = 0; m_exp = 0; m_addr = 0; m_rw = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        int w;
        @(negedge clk);
        if (m_drop >= 0) req_valid[m_drop] = 1'b0;
        m_drop = -1;
        for (int i = 0; i < N; i++)
          if (!req_valid[i] && $urandom_range(0, 2) == 0)
            set_req(i, 1'($urandom), 10'($urandom), 8'($urandom), $urandom);
        if (cyc == t_done) begin
          spi_done = 1'b1;
          spi_read_data = m_rd;
        end else if ((cyc >= t_free || cyc == t_start || cyc == t_rsp) && $urandom_range(0, 7) == 0) begin
          spi_done = 1'b1;
          spi_read_data = $urandom;
        end else begin
          spi_done = 1'b0;
        end
        #1;
        w = (cyc >= t_free) ? winner(req_valid, m_ptr) : -1;
        exp_ready = (w >= 0) ? N'(1 << w) : '0;
        chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
        chk("rnd_start", 64'({spi_start, spi_abort}), 64'({cyc == t_start, 1'b0}));
        if (cyc == t_start)
          chk("rnd_cmd", 64'({spi_read_write, spi_address}), 64'({m_rw, m_addr}));
        chk("rnd_rsp", 64'(rsp_valid), (cyc == t_rsp) ? 64'(1 << m_g) : 64'd0);
        if (cyc == t_rsp) chk("rnd_rdata", 64'({rsp_err, rsp_rdata}), 64'({1'b0, m_exp}));
        if (w >= 0) begin
          m_g     = w;
          m_ptr   = (w + 1) % N;
          m_rw    = req_rw[w];
          m_addr  = req_addr[w*AW +: AW];
          t_start = cyc + 1;
          t_done  = t_start + int'($urandom_range(1, 6));
          t_rsp   = t_done + 1;
          t_free  = t_rsp + 1;
          m_rd    = $urandom;
          m_exp   = m_rw ? 32'h0 : m_rd;
          m_drop  = w;
        end
      end
    end
    req_valid = '0;
    spi_done  = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
